// File: rtl/alu_mc_if.sv
// Request/response bundle for the multi-cycle ALU: operand handshake in,
// result handshake out. The producer/consumer side uses master, the ALU uses slave.
interface alu_mc_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic             flag_dz;
    logic             flag_ill;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flag_z, flag_c, flag_v, flag_dz, flag_ill
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flag_z, flag_c, flag_v, flag_dz, flag_ill
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add MUL and
// restoring DIVU/REMU, valid/ready on both sides, one operation in flight.
module alu_mc #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1,
    parameter bit DIV_EN = 1'b1
) (
    input logic     clk,
    input logic     rst,
    alu_mc_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] x_q;    // MUL: shifted multiplicand; DIV: dividend shifting into quotient
    logic [WIDTH-1:0] y_q;    // MUL: multiplier shifting right; DIV: divisor
    logic [WIDTH-1:0] acc_q;  // MUL: partial product; DIV: partial remainder
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             z_q, c_q, v_q, dz_q, ill_q;

    logic [WIDTH:0]   add_full, sub_full;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v, sc_dz, sc_ill, is_iter;

    logic [WIDTH-1:0] mul_acc_d;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_sub;
    logic             div_ge;
    logic [WIDTH-1:0] rem_d, quo_d, iter_res;

    // Single-cycle results are formed from the request operands and captured at the accept edge.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        sc_res   = '0;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        sc_dz    = 1'b0;
        sc_ill   = 1'b0;
        is_iter  = 1'b0;
        shamt    = bus.b[SHW-1:0];
        add_full = {1'b0, bus.a} + {1'b0, bus.b};
        sub_full = {1'b0, bus.a} - {1'b0, bus.b};
        case (bus.op)
            OP_ADD: begin
                sc_res = add_full[WIDTH-1:0];
                sc_c   = add_full[WIDTH];
                sc_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_full[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sub_full[WIDTH-1:0];
                sc_c   = sub_full[WIDTH];
                sc_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_full[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  sc_res = bus.a & bus.b;
            OP_OR:   sc_res = bus.a | bus.b;
            OP_XOR:  sc_res = bus.a ^ bus.b;
            OP_SLL:  sc_res = bus.a << shamt;
            OP_SRL:  sc_res = bus.a >> shamt;
            OP_SRA:  sc_res = $unsigned($signed(bus.a) >>> shamt);
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            OP_MUL: begin
                if (MUL_EN) is_iter = 1'b1;
                else        sc_ill  = 1'b1;
            end
            OP_DIVU, OP_REMU: begin
                if (!DIV_EN) begin
                    sc_ill = 1'b1;
                end else if (bus.b == '0) begin
                    sc_res = (bus.op == OP_DIVU) ? '1 : bus.a;
                    sc_dz  = 1'b1;
                end else begin
                    is_iter = 1'b1;
                end
            end
            default: sc_ill = 1'b1;
        endcase
    end

    // One iteration step; the difference fits WIDTH bits whenever it is taken (remainder < divisor).
    always_comb begin
        mul_acc_d = y_q[0] ? acc_q + x_q : acc_q;
        div_shift = {acc_q, x_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, y_q};
        div_sub   = div_shift[WIDTH-1:0] - y_q;
        rem_d     = div_ge ? div_sub : div_shift[WIDTH-1:0];
        quo_d     = {x_q[WIDTH-2:0], div_ge};
        if (op_q == OP_MUL)       iter_res = mul_acc_d;
        else if (op_q == OP_DIVU) iter_res = quo_d;
        else                      iter_res = rem_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_d = is_iter ? S_ITER : S_DONE;
            end
            S_ITER: if (cnt_q == CW'(1)) state_d = S_DONE;
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            dz_q     <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (bus.in_valid) begin
                    op_q  <= bus.op;
                    x_q   <= bus.a;
                    y_q   <= bus.b;
                    acc_q <= '0;
                    cnt_q <= CW'(WIDTH);
                    if (!is_iter) begin
                        result_q <= sc_res;
                        z_q      <= (sc_res == '0);
                        c_q      <= sc_c;
                        v_q      <= sc_v;
                        dz_q     <= sc_dz;
                        ill_q    <= sc_ill;
                    end
                end
                S_ITER: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (op_q == OP_MUL) begin
                        acc_q <= mul_acc_d;
                        x_q   <= x_q << 1;
                        y_q   <= y_q >> 1;
                    end else begin
                        acc_q <= rem_d;
                        x_q   <= quo_d;
                    end
                    if (cnt_q == CW'(1)) begin
                        result_q <= iter_res;
                        z_q      <= (iter_res == '0);
                        c_q      <= 1'b0;
                        v_q      <= 1'b0;
                        dz_q     <= 1'b0;
                        ill_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result   = result_q;
    assign bus.flag_z   = z_q;
    assign bus.flag_c   = c_q;
    assign bus.flag_v   = v_q;
    assign bus.flag_dz  = dz_q;
    assign bus.flag_ill = ill_q;
endmodule
